// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush decode for the 5-stage core; define PIPE_CTRL_PERF_EN for stall/flush counters
module pipe_hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mem_busy,
  input  logic             mc_start,
  input  logic             mc_done,
  input  logic             br_miss,
  input  logic             load_use,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             clr_ifid,
  output logic             clr_idex,
  output logic             clr_exmem,
  output logic             clr_memwb,
  output logic             mc_err,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush
);
  localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  typedef enum logic {RUN, MC_WAIT} state_e;
  state_e          state_q, state_d;
  logic            done_pend_q, done_pend_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            mc_err_q, mc_err_d;
  logic            tmo_hit, rel;
  assign tmo_hit = tmo_q == TW'(MC_TIMEOUT - 1);
  assign rel     = mc_done | done_pend_q | tmo_hit;
  assign mc_err  = mc_err_q;
  always_comb begin
    {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b11111;
    {clr_ifid, clr_idex, clr_exmem, clr_memwb} = 4'b0000;
    state_d     = state_q;
    done_pend_d = done_pend_q;
    tmo_d       = tmo_q;
    mc_err_d    = mc_err_q;
    if (!rstn) begin
      {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
      {clr_ifid, clr_idex, clr_exmem, clr_memwb} = 4'b1111;
    end else if (mem_busy) begin
      {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
      done_pend_d = done_pend_q | (state_q == MC_WAIT && mc_done);
    end else if (state_q == MC_WAIT) begin
      if (rel) begin
        state_d     = RUN;
        done_pend_d = 1'b0;
        tmo_d       = '0;
        mc_err_d    = mc_err_q | !(mc_done | done_pend_q);
      end else begin
        {en_pc, en_ifid, en_idex} = 3'b000;
        clr_exmem = 1'b1;
        tmo_d     = tmo_q + TW'(1);
      end
    end else if (mc_start && !mc_done) begin
      {en_pc, en_ifid, en_idex} = 3'b000;
      clr_exmem = 1'b1;
      state_d   = MC_WAIT;
      tmo_d     = TW'(1);
    end else if (br_miss) begin
      {clr_ifid, clr_idex} = 2'b11;
    end else if (load_use) begin
      {en_pc, en_ifid} = 2'b00;
      clr_idex = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= RUN;
      done_pend_q <= 1'b0;
      tmo_q       <= '0;
      mc_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_pend_q <= done_pend_d;
      tmo_q       <= tmo_d;
      mc_err_q    <= mc_err_d;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             flush_w;
  // flush counts only when the mispredict rule actually wins the decode
  assign flush_w = !mem_busy && state_q == RUN && !(mc_start && !mc_done) && br_miss;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!en_pc && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (flush_w && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
    end
  end
  assign perf_stall = stall_q;
  assign perf_flush = flush_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif
endmodule
